// File: rtl/os_xor_acc_ctrl.sv
// Output-stationary XOR2 accumulate controller: carry-less product per beat, XOR-folded into a held result.
// Optional product pipeline register (and DRAIN state) when OS_XOR_ACC_PIPE_EN is defined.
module os_xor_acc_ctrl #(
  parameter int W     = 8,
  parameter int LEN_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   cfg_len,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-2:0]     out_y,
  output logic [LEN_W:0]     out_beats
);

`ifdef OS_XOR_ACC_PIPE_EN
  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
`endif

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic [2*W-2:0]     acc;
  logic [2*W-2:0]     prod;
  logic               hs;
  logic               last;

  // GF(2) carry-less multiply: each output bit is the parity of its partial products
  always_comb begin
    prod = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        prod[i+j] = prod[i+j] ^ (in_a[i] & in_b[j]);
      end
    end
  end

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign hs        = in_valid && in_ready;
  assign last      = hs && (cnt == len_q);
  assign out_y     = acc;
  assign out_beats = (state == DONE) ? ({1'b0, len_q} + (LEN_W+1)'(1)) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = ACC;
`ifdef OS_XOR_ACC_PIPE_EN
      ACC:   if (last) state_nxt = DRAIN;
      DRAIN: state_nxt = DONE;
`else
      ACC:  if (last) state_nxt = DONE;
`endif
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

`ifdef OS_XOR_ACC_PIPE_EN
  logic [2*W-2:0] prod_q;
  logic           prod_vld;

  // Product is registered on the handshake and folded into acc one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      cnt      <= '0;
      acc      <= '0;
      prod_q   <= '0;
      prod_vld <= 1'b0;
    end else if (state == IDLE && start) begin
      len_q    <= cfg_len;
      cnt      <= '0;
      acc      <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= hs;
      if (hs) begin
        prod_q <= prod;
        cnt    <= cnt + 1'b1;
      end
      if (prod_vld) acc <= acc ^ prod_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      cnt   <= '0;
      acc   <= '0;
    end else if (state == IDLE && start) begin
      len_q <= cfg_len;
      cnt   <= '0;
      acc   <= '0;
    end else if (hs) begin
      acc <= acc ^ prod;
      cnt <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_os_xor_acc_ctrl.sv
// Directed bench for os_xor_acc_ctrl: hand-computed carry-less results, latency, backpressure, reset abort.
module tb_os_xor_acc_ctrl;
`ifdef OS_XOR_ACC_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  cfg_len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_y;
  logic [4:0]  out_beats;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] va [16];
  logic [7:0] vb [16];

  os_xor_acc_ctrl #(.W(8), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_beats(out_beats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".in_ready"}, 32'(in_ready), 0);
    chk({tag, ".out_valid"}, 32'(out_valid), 0);
    chk({tag, ".out_y"}, 32'(out_y), 0);
    chk({tag, ".out_beats"}, 32'(out_beats), 0);
  endtask

  // Runs one job from va/vb; gap = idle cycles between beats, hold = cycles of out_ready=0
  task automatic run_job(input string tag, input logic [3:0] len, input int gap, input int hold,
                         input bit poke_start, input bit chk_ready_run,
                         input logic [14:0] exp_y, input logic [4:0] exp_beats);
    int n;
    cfg_len = len;
    start   = 1'b1;
    step();
    start   = 1'b0;
    cfg_len = 4'hA;
    chk({tag, ".busy_after_start"}, 32'(busy), 1);
    for (int k = 0; k <= int'(len); k++) begin
      if (chk_ready_run) chk({tag, ".in_ready_run"}, 32'(in_ready), 1);
      in_valid = 1'b1;
      in_a = va[k];
      in_b = vb[k];
      step();
      in_valid = 1'b0;
      in_a = 8'hXX;
      in_b = 8'hXX;
      if (k != int'(len)) repeat (gap) step();
    end
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'(LAT));
    chk({tag, ".out_y"}, 32'(out_y), 32'(exp_y));
    chk({tag, ".out_beats"}, 32'(out_beats), 32'(exp_beats));
    for (int h = 0; h < hold; h++) begin
      if (poke_start && h == 3) start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, ".hold_valid"}, 32'(out_valid), 1);
      chk({tag, ".hold_y"}, 32'(out_y), 32'(exp_y));
      chk({tag, ".hold_in_ready"}, 32'(in_ready), 0);
      chk({tag, ".hold_busy"}, 32'(busy), 1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".valid_drop"}, 32'(out_valid), 0);
    chk({tag, ".busy_drop"}, 32'(busy), 0);
    chk({tag, ".beats_drop"}, 32'(out_beats), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    #12;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    step();
    check_idle_outputs("post_reset_idle");

    va[0] = 8'h03; vb[0] = 8'h03;
    run_job("single", 4'd0, 0, 0, 1'b0, 1'b0, 15'h0005, 5'd1);

    va[0] = 8'hFF; vb[0] = 8'hFF;
    run_job("full", 4'd0, 0, 0, 1'b0, 1'b0, 15'h5555, 5'd1);

    va[0] = 8'h0F; vb[0] = 8'h0F;
    va[1] = 8'h0F; vb[1] = 8'h0F;
    va[2] = 8'h81; vb[2] = 8'h02;
    run_job("cancel_gap", 4'd2, 3, 0, 1'b0, 1'b0, 15'h0102, 5'd3);

    va[0] = 8'h81; vb[0] = 8'h02;
    run_job("backpressure", 4'd0, 0, 10, 1'b1, 1'b0, 15'h0102, 5'd1);
    step();
    chk("backpressure.start_ignored", 32'(busy), 0);

    // Abort a job after 3 accepted beats
    cfg_len = 4'd7;
    start   = 1'b1;
    step();
    start   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_a = 8'h03; in_b = 8'h03;
      step();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midjob_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    va[0] = 8'h02; vb[0] = 8'h04;
    run_job("after_reset", 4'd0, 0, 0, 1'b0, 1'b0, 15'h0008, 5'd1);

    for (int k = 0; k < 16; k++) begin
      va[k] = 8'h01; vb[k] = 8'h01;
    end
    run_job("max_len", 4'd15, 0, 0, 1'b0, 1'b1, 15'h0000, 5'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
